// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_ADDR     = 4'd1;
    localparam state_t ST_ADDR_ACK = 4'd2;
    localparam state_t ST_PTR      = 4'd3;
    localparam state_t ST_PTR_ACK  = 4'd4;
    localparam state_t ST_WR_BYTE  = 4'd5;
    localparam state_t ST_WR_ACK   = 4'd6;
    localparam state_t ST_RD_BYTE  = 4'd7;
    localparam state_t ST_IGNORE   = 4'd8;

    localparam logic ACK      = 1'b0;
    localparam logic NACK     = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_reg_target_if.sv
// Register-bank side of the I2C target: write strobe out, combinational read back in.
interface i2c_reg_target_if #(
    parameter int unsigned REG_AW = 3
);
    logic              reg_wr_en;
    logic [REG_AW-1:0] reg_wr_addr;
    logic [7:0]        reg_wr_data;
    logic [REG_AW-1:0] reg_rd_addr;
    logic [7:0]        reg_rd_data;

    modport master (
        output reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_addr,
        input  reg_rd_data
    );

    modport slave (
        input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_addr,
        output reg_rd_data
    );
endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and derives edge, START and STOP pulses.
module i2c_bus_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Idle bus is high on both lines, so reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target exposing an external register bank with DS1307-style auto-incrementing pointer.
module i2c_reg_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = 7'h68,
    parameter int unsigned REG_AW   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i2c_scl,
    inout  wire                      i2c_sda,
    i2c_reg_target_if.master         regs,
    output logic                     busy
);
    logic              sda_s;
    logic              scl_rise;
    logic              scl_fall;
    logic              start_det;
    logic              stop_det;

    state_t            state;
    logic [3:0]        bit_cnt;
    logic [7:0]        sr;
    logic [7:0]        shift_in;
    logic [REG_AW-1:0] ptr;
    logic              rw;
    logic              sda_oe;
    logic              wr_en;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              last_bit;

    i2c_bus_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl       (i2c_scl),
        .sda       (i2c_sda),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    assign shift_in = {sr[6:0], sda_s};
    assign last_bit = (bit_cnt == 4'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            bit_cnt <= 4'd0;
            sr      <= 8'd0;
            ptr     <= '0;
            rw      <= RW_WRITE;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'd0;
            busy    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (stop_det) begin
                state   <= ST_IDLE;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= 4'd0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            sr      <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (last_bit) begin
                                rw <= sda_s;
                                if (shift_in[7:1] == DEV_ADDR) begin
                                    state <= ST_ADDR_ACK;
                                    busy  <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_PTR, ST_WR_BYTE: begin
                        if (scl_rise) begin
                            sr      <= shift_in;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (last_bit && state == ST_PTR) begin
                                ptr   <= shift_in[REG_AW-1:0];
                                state <= ST_PTR_ACK;
                            end else if (last_bit) begin
                                wr_en   <= 1'b1;
                                wr_addr <= ptr;
                                wr_data <= shift_in;
                                ptr     <= ptr + 1'b1;
                                state   <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
                        // First fall starts the ACK low, second fall ends it.
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                if (state == ST_ADDR_ACK && rw == RW_READ) begin
                                    state  <= ST_RD_BYTE;
                                    sr     <= {regs.reg_rd_data[6:0], 1'b0};
                                    sda_oe <= ~regs.reg_rd_data[7];
                                end else if (state == ST_ADDR_ACK) begin
                                    state <= ST_PTR;
                                end else begin
                                    state <= ST_WR_BYTE;
                                end
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd8) begin
                                ptr <= ptr + 1'b1;
                                if (sda_s == NACK) begin
                                    state <= ST_IGNORE;
                                    busy  <= 1'b0;
                                end
                            end
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd9) begin
                                sr      <= {regs.reg_rd_data[6:0], 1'b0};
                                sda_oe  <= ~regs.reg_rd_data[7];
                                bit_cnt <= 4'd0;
                            end else if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                            end else if (bit_cnt != 4'd0) begin
                                sda_oe <= ~sr[7];
                                sr     <= {sr[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Open drain: only ever pull low.
    assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

    assign regs.reg_wr_en   = wr_en;
    assign regs.reg_wr_addr = wr_addr;
    assign regs.reg_wr_data = wr_data;
    assign regs.reg_rd_addr = ptr;

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
- I2C target (slave) end of the bus driven by the team's I2C master (realTime_i2c).
- Exposes a small register bank, such as the RTC register model, behind a 7-bit device address, with DS1307-style pointer semantics: the first write byte sets the register pointer, later bytes write or read with auto-increment.
- Sits next to the register storage. The block owns no storage itself: writes leave as single-cycle strobes, reads take combinational data from the bank.

Parameters:
- DEV_ADDR, 7'h68, 7-bit device address matched after START.
- REG_AW, 3, register pointer width; bank depth is 2**REG_AW and the pointer wraps modulo that depth.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i2c_scl  input  1  bus clock from the master.
- i2c_sda  inout  1  open-drain data: driven 0 or 'bz only, never driven 1.
- reg_wr_en  output  1  one-cycle write strobe.
- reg_wr_addr  output  REG_AW  write register index.
- reg_wr_data  output  8  write data byte.
- reg_rd_addr  output  REG_AW  current pointer, for combinational read.
- reg_rd_data  input  8  bank contents at reg_rd_addr.
- busy  output  1  high from an addressed START until STOP or NACK release.

Behaviour:
- Input sync: SCL and SDA each pass through 2 flops, then a third flop for edge detection. All bus decisions use the synced values. Detection latency is 3 clk after a pin changes.
- START / repeated START: SDA falls while SCL is high. From any state, go to ADDR and clear the bit counter.
- STOP: SDA rises while SCL is high. From any state, go to IDLE, release SDA, drop busy.
- Sampling and driving: data is sampled on the SCL rise. The target changes SDA only on the SCL fall.
- States and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first.
    - Bits [7:1] == DEV_ADDR: go to ADDR_ACK and set busy.
    - Mismatch: go to IGNORE, SDA never driven.
  - ADDR_ACK: drive SDA=0 from the fall after the 8th bit to the fall after the 9th.
    - R/W=0: go to PTR.
    - R/W=1: go to RD_BYTE, latching reg_rd_data into the shift register on that same fall.
  - PTR: shift 8 bits. pointer <= byte[REG_AW-1:0]; upper bits are ignored. Then PTR_ACK (ack as above), then WR_BYTE.
  - WR_BYTE: shift 8 bits. On the 8th SCL rise, assert reg_wr_en for exactly one clk with reg_wr_addr=pointer and reg_wr_data=byte, then increment the pointer (wrap). Then WR_ACK, then WR_BYTE.
  - RD_BYTE: drive shift-register bits MSB first on the SCL falls; a '1' bit is released (z). After the 8th bit, release SDA and sample the master's bit on the 9th rise.
    - ACK (0): pointer++, latch the new reg_rd_data on the 9th fall, stay in RD_BYTE.
    - NACK (1): pointer++, go to IGNORE, drop busy.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer persists across transactions: a read without a preceding pointer write starts at the last pointer. Reset clears it to 0.
- Reset values: i2c_sda = z, reg_wr_en = 0, reg_wr_addr = 0, reg_wr_data = 0, reg_rd_addr = 0, busy = 0, state = IDLE. Reset mid-transfer releases SDA on the next clk and suppresses any pending write strobe.
- STOP or START mid-byte: the partial byte is discarded, no strobe is issued, and the pointer is unchanged.
- No clock stretching: SCL is never driven.

Decomposition:
- Shared package i2c_pkg holds:
  - the state enumeration;
  - the constants ACK=1'b0, NACK=1'b1, RW_WRITE=1'b0, RW_READ=1'b1, SYNC_STAGES=2.
- One natural sub-module, i2c_bus_sync: synchronizers plus edge detection. It outputs scl_rise, scl_fall, start_det, stop_det and sda_s, and is reusable by the master.

Test Plan:
(Bench: 50 MHz clk; master model with a 40-clk SCL period; pull-up model is 'bz resolving to 1.)
- Address mismatch: START, 0xA0, 0x01, STOP -> SDA high on every 9th clock, no reg_wr_en, busy stays 0.
- Burst write: START, 0xD0, 0x02, 0x3C, 0x45, STOP -> ACK on all 4 bytes. Exactly two reg_wr_en pulses: (2, 0x3C) then (3, 0x45). Pointer ends at 4, busy falls at STOP.
- Pointer read with repeated START: bank preloaded with reg[k]=0x10+k. START, 0xD0, 0x05, Sr, 0xD1; read 2 bytes, master ACK then NACK; STOP -> bytes 0x15, 0x16; SDA released after the NACK; pointer ends at 7.
- Wrap-around: START, 0xD0, 0x07, 0xAA, 0xBB, STOP -> writes (7, 0xAA) then (0, 0xBB).
- Abort cases:
  - STOP after 4 data bits of a write byte -> no strobe, state IDLE.
  - rst pulsed for 1 clk while the target drives an ACK low -> SDA is z on the next clk, all outputs at reset values.
